// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core MEM stage and a
// debug/loader port. The core wins by default. A pending debug request wins after MAX_WAIT
// lost cycles. d_lock holds ownership so the debug port can run back-to-back bursts.
// Optional statistics counters are built only when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter #(
    parameter int unsigned AW       = 32,
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [AW-1:0]     c_addr,
    input  logic [31:0]       c_wdata,
    input  logic [2:0]        c_funct3,
    output logic              c_stall,
    output logic              c_rvalid,
    output logic [31:0]       c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_lock,
    input  logic [AW-1:0]     d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [2:0]        d_funct3,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [AW-1:0]     m_addr,
    output logic [31:0]       m_wdata,
    output logic [2:0]        m_funct3,
    input  logic [31:0]       m_rdata,
    output logic [CNT_W-1:0]  stat_stalls,
    output logic [CNT_W-1:0]  stat_dbg_grants
);

    // Wide enough to hold MAX_WAIT; at least one bit so MAX_WAIT=0 still elaborates.
    localparam int unsigned WaitW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);

    typedef enum logic [0:0] {StNormal, StLock} state_e;

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic             rd_core_q, rd_core_d;
    logic             rd_dbg_q, rd_dbg_d;
    logic             c_gnt;

    // Combinational grant decision; everything is forced idle while reset is asserted.
    always_comb begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        if (rst) begin
            if (state_q == StLock) begin
                d_gnt = d_req;
            end else begin
                d_gnt = d_req && (!c_req || (wait_cnt_q == WaitMax));
                c_gnt = c_req && !d_gnt;
            end
        end
        c_stall = rst && c_req && !c_gnt;
    end

    // Memory-side mux; fields are zero when nobody is granted.
    always_comb begin
        m_en     = c_gnt | d_gnt;
        m_we     = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        m_funct3 = '0;
        if (d_gnt) begin
            m_we     = d_we;
            m_addr   = d_addr;
            m_wdata  = d_wdata;
            m_funct3 = d_funct3;
        end else if (c_gnt) begin
            m_we     = c_we;
            m_addr   = c_addr;
            m_wdata  = c_wdata;
            m_funct3 = c_funct3;
        end
    end

    // Next-state: lock FSM, starvation counter and read-owner tags.
    always_comb begin
        state_d = state_q;
        if (state_q == StNormal) begin
            if (d_gnt && d_lock) state_d = StLock;
        end else begin
            if ((d_gnt && !d_lock) || !d_req) state_d = StNormal;
        end

        wait_cnt_d = '0;
        if (d_req && !d_gnt) begin
            wait_cnt_d = (wait_cnt_q == WaitMax) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end

        rd_core_d = c_gnt && !c_we;
        rd_dbg_d  = d_gnt && !d_we;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StNormal;
            wait_cnt_q <= '0;
            rd_core_q  <= 1'b0;
            rd_dbg_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rd_core_q  <= rd_core_d;
            rd_dbg_q   <= rd_dbg_d;
        end
    end

    // Read return: data goes to both ports, rvalid qualifies it. Masked during reset so a
    // read interrupted by reset never reports.
    always_comb begin
        c_rvalid = rst && rd_core_q;
        d_rvalid = rst && rd_dbg_q;
        c_rdata  = m_rdata;
        d_rdata  = m_rdata;
    end

`ifdef DMEM_ARB_STATS_EN
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CNT_W-1:0] stalls_q, stalls_d;
    logic [CNT_W-1:0] dbg_grants_q, dbg_grants_d;

    // Saturating statistics counters.
    always_comb begin
        stalls_d     = stalls_q;
        dbg_grants_d = dbg_grants_q;
        if (c_stall && (stalls_q != CntMax)) stalls_d = stalls_q + 1'b1;
        if (d_gnt && (dbg_grants_q != CntMax)) dbg_grants_d = dbg_grants_q + 1'b1;
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stalls_q     <= '0;
            dbg_grants_q <= '0;
        end else begin
            stalls_q     <= stalls_d;
            dbg_grants_q <= dbg_grants_d;
        end
    end

    assign stat_stalls     = stalls_q;
    assign stat_dbg_grants = dbg_grants_q;
`else
    assign stat_stalls     = '0;
    assign stat_dbg_grants = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter (default parameters).
// Inputs change 1 time unit after posedge; outputs are sampled on the negedge.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_we;
    logic [31:0] c_addr, c_wdata;
    logic [2:0]  c_funct3;
    logic        c_stall, c_rvalid;
    logic [31:0] c_rdata;
    logic        d_req, d_we, d_lock;
    logic [31:0] d_addr, d_wdata;
    logic [2:0]  d_funct3;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        m_en, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [2:0]  m_funct3;
    logic [31:0] m_rdata;
    logic [15:0] stat_stalls, stat_dbg_grants;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .c_req           (c_req),
        .c_we            (c_we),
        .c_addr          (c_addr),
        .c_wdata         (c_wdata),
        .c_funct3        (c_funct3),
        .c_stall         (c_stall),
        .c_rvalid        (c_rvalid),
        .c_rdata         (c_rdata),
        .d_req           (d_req),
        .d_we            (d_we),
        .d_lock          (d_lock),
        .d_addr          (d_addr),
        .d_wdata         (d_wdata),
        .d_funct3        (d_funct3),
        .d_gnt           (d_gnt),
        .d_rvalid        (d_rvalid),
        .d_rdata         (d_rdata),
        .m_en            (m_en),
        .m_we            (m_we),
        .m_addr          (m_addr),
        .m_wdata         (m_wdata),
        .m_funct3        (m_funct3),
        .m_rdata         (m_rdata),
        .stat_stalls     (stat_stalls),
        .stat_dbg_grants (stat_dbg_grants)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    `ifdef DMEM_ARB_STATS_EN
    localparam logic [31:0] ExpStat = 32'd2;
    `else
    localparam logic [31:0] ExpStat = 32'd0;
    `endif

    initial begin
        logic exp_d;
        logic prev_d;

        rst = 1'b0; c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10; c_wdata = '0; c_funct3 = 3'd2;
        d_req = 1'b1; d_we = 1'b0; d_lock = 1'b0; d_addr = 32'h200; d_wdata = '0;
        d_funct3 = 3'd2; m_rdata = 32'h0;

        // Reset held with both requesting.
        next_cycle();
        @(negedge clk);
        check("rst_m_en", 32'(m_en), 32'd0);
        check("rst_c_stall", 32'(c_stall), 32'd0);
        check("rst_d_gnt", 32'(d_gnt), 32'd0);
        next_cycle();
        rst = 1'b1;

        // Contention: debug wins on cycles 4 and 9, core otherwise.
        prev_d = 1'b0;
        for (int i = 0; i < 10; i++) begin
            exp_d = (i == 4) || (i == 9);
            m_rdata = 32'hA000_0000 + 32'(i);
            @(negedge clk);
            check($sformatf("cont%0d_d_gnt", i), 32'(d_gnt), 32'(exp_d));
            check($sformatf("cont%0d_c_stall", i), 32'(c_stall), 32'(exp_d));
            check($sformatf("cont%0d_m_en", i), 32'(m_en), 32'd1);
            check($sformatf("cont%0d_m_addr", i), m_addr, exp_d ? 32'h200 : 32'h10);
            check($sformatf("cont%0d_c_rvalid", i), 32'(c_rvalid), 32'(i > 0 && !prev_d));
            check($sformatf("cont%0d_d_rvalid", i), 32'(d_rvalid), 32'(prev_d));
            prev_d = exp_d;
            next_cycle();
        end
        c_req = 1'b0; d_req = 1'b0; m_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        check("cont_end_d_rvalid", 32'(d_rvalid), 32'd1);
        check("cont_end_d_rdata", d_rdata, 32'hCAFE_F00D);
        check("cont_end_c_rvalid", 32'(c_rvalid), 32'd0);
        check("cont_end_m_en", 32'(m_en), 32'd0);
        check("stat_stalls", 32'(stat_stalls), ExpStat);
        check("stat_dbg_grants", 32'(stat_dbg_grants), ExpStat);
        next_cycle();

        // Core read only.
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10; c_funct3 = 3'd4;
        @(negedge clk);
        check("crd_m_en", 32'(m_en), 32'd1);
        check("crd_m_addr", m_addr, 32'h10);
        check("crd_m_we", 32'(m_we), 32'd0);
        check("crd_m_funct3", 32'(m_funct3), 32'd4);
        next_cycle();
        c_req = 1'b0; m_rdata = 32'h1234_5678;
        @(negedge clk);
        check("crd_c_rvalid", 32'(c_rvalid), 32'd1);
        check("crd_c_rdata", c_rdata, 32'h1234_5678);
        check("crd_d_rvalid", 32'(d_rvalid), 32'd0);
        check("idle_m_addr", m_addr, 32'h0);
        next_cycle();

        // Core write: no rvalid afterwards.
        c_req = 1'b1; c_we = 1'b1; c_addr = 32'h44; c_wdata = 32'h5555_AAAA;
        @(negedge clk);
        check("cwr_m_we", 32'(m_we), 32'd1);
        check("cwr_m_wdata", m_wdata, 32'h5555_AAAA);
        next_cycle();
        c_req = 1'b0; c_we = 1'b0;
        @(negedge clk);
        check("cwr_c_rvalid", 32'(c_rvalid), 32'd0);
        next_cycle();

        // Lock burst: three debug writes, core arrives on the second.
        d_req = 1'b1; d_we = 1'b1; d_lock = 1'b1; d_addr = 32'h100; d_wdata = 32'h1;
        @(negedge clk);
        check("lk0_d_gnt", 32'(d_gnt), 32'd1);
        check("lk0_m_addr", m_addr, 32'h100);
        check("lk0_m_we", 32'(m_we), 32'd1);
        check("lk0_c_stall", 32'(c_stall), 32'd0);
        next_cycle();
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h20; d_addr = 32'h104; d_wdata = 32'h2;
        @(negedge clk);
        check("lk1_d_gnt", 32'(d_gnt), 32'd1);
        check("lk1_c_stall", 32'(c_stall), 32'd1);
        check("lk1_m_addr", m_addr, 32'h104);
        next_cycle();
        d_lock = 1'b0; d_addr = 32'h108; d_wdata = 32'h3;
        @(negedge clk);
        check("lk2_d_gnt", 32'(d_gnt), 32'd1);
        check("lk2_c_stall", 32'(c_stall), 32'd1);
        check("lk2_m_wdata", m_wdata, 32'h3);
        next_cycle();
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        check("lk3_d_gnt", 32'(d_gnt), 32'd0);
        check("lk3_c_stall", 32'(c_stall), 32'd0);
        check("lk3_m_addr", m_addr, 32'h20);
        check("lk3_d_rvalid", 32'(d_rvalid), 32'd0);
        next_cycle();

        // Reset mid-LOCK with a debug read outstanding.
        c_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_lock = 1'b1; d_addr = 32'h300;
        @(negedge clk);
        check("rl0_d_gnt", 32'(d_gnt), 32'd1);
        next_cycle();
        c_req = 1'b1; c_addr = 32'h30;
        @(negedge clk);
        check("rl1_c_stall", 32'(c_stall), 32'd1);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rl2_m_en", 32'(m_en), 32'd0);
        check("rl2_d_gnt", 32'(d_gnt), 32'd0);
        check("rl2_d_rvalid", 32'(d_rvalid), 32'd0);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("rl3_m_en", 32'(m_en), 32'd1);
        check("rl3_m_addr", m_addr, 32'h30);
        check("rl3_d_gnt", 32'(d_gnt), 32'd0);
        check("rl3_c_stall", 32'(c_stall), 32'd0);
        check("rl3_d_rvalid", 32'(d_rvalid), 32'd0);
        check("rl3_stat_stalls", 32'(stat_stalls), 32'd0);
        next_cycle();
        c_req = 1'b0; d_req = 1'b0; m_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        check("rl4_c_rvalid", 32'(c_rvalid), 32'd1);
        check("rl4_d_rvalid", 32'(d_rvalid), 32'd0);
        check("rl4_c_rdata", c_rdata, 32'h0BAD_F00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory between the pipeline MEM stage (core port) and a debug/loader port (debug port). Arbitration is fixed-priority with a starvation bound: the core wins by default, and the debug port is guaranteed a grant after MAX_WAIT lost cycles. A lock mode lets the debug port run back-to-back bursts. The block sits between EX_MEM/MEM_WB and the data memory, and drives a stall request into the hazard detection unit whenever the core loses arbitration.

## Interface
- AW, 32, address width
- MAX_WAIT, 4, maximum consecutive cycles a pending debug request may lose (0 means debug always wins)
- CNT_W, 16, statistics counter width
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous, active-low reset
- c_req / c_we  in  1  core access request / write enable
- c_addr  in  AW  core byte address
- c_wdata  in  32  core write data
- c_funct3  in  3  core access size/sign, passed through unchanged
- c_stall  out  1  core request pending but not granted this cycle
- c_rvalid  out  1  core read data valid
- c_rdata  out  32  core read data
- d_req / d_we / d_lock  in  1  debug request / write enable / hold ownership after this access
- d_addr  in  AW; d_wdata  in  32; d_funct3  in  3  debug access fields
- d_gnt  out  1  debug access accepted this cycle
- d_rvalid  out  1; d_rdata  out  32  debug read return
- m_en / m_we  out  1  memory access strobe / write
- m_addr  out  AW; m_wdata  out  32; m_funct3  out  3  memory access fields
- m_rdata  in  32  memory read data, valid the cycle after a read strobe
- stat_stalls  out  CNT_W; stat_dbg_grants  out  CNT_W  statistics (see Configuration)

## Operation
- States: NORMAL, LOCK.
- Grant decision is combinational each cycle:
  - In NORMAL, debug is granted when d_req && (!c_req || wait_cnt == MAX_WAIT). Otherwise the core is granted when c_req.
  - In LOCK, debug is granted when d_req. The core is never granted.
- wait_cnt (saturating at MAX_WAIT) increments when d_req && !d_gnt. It clears on d_gnt or on !d_req.
- NORMAL to LOCK: on d_gnt with d_lock=1.
- LOCK to NORMAL: on d_gnt with d_lock=0, or on any cycle with d_req=0.
- m_* is a mux of the granted port's fields.
  - m_en = c_gnt | d_gnt; m_we = granted port's we.
  - With no grant, m_* fields are held at 0.
- Read return:
  - On a granted read, a registered owner tag (rd_core, rd_dbg) is set.
  - The next cycle, the owner's x_rvalid=1. m_rdata is routed to both c_rdata and d_rdata; rvalid alone qualifies the data.
  - Writes produce no rvalid.
- c_stall = c_req && !c_gnt. The core must hold all c_* fields stable while stalled.
- The debug port must hold its fields while d_req && !d_gnt.

## Timing
- Grant, m_en and c_stall are same-cycle (combinational from inputs and state). Read latency is 1 cycle after grant.
- Back-to-back accesses are allowed every cycle. Throughput is 1 access/cycle total.
- Reset (rst=0 sampled at posedge):
  - State returns to NORMAL; wait_cnt=0; c_rvalid=d_rvalid=0; stats=0.
  - While rst=0, c_stall=0, d_gnt=0 and m_en=0, regardless of requests.
- Reset mid-LOCK or mid-read: the lock is abandoned and the pending rvalid is dropped. The first cycle after release follows NORMAL arbitration.
- Simultaneous requests at wait_cnt==MAX_WAIT: debug wins, and the core stalls exactly 1 cycle unless d_lock=1.
- A read and a new grant in the same cycle: the rvalid of the previous access and the new m_en coexist.

## Configuration
- DMEM_ARB_STATS_EN defined:
  - stat_stalls counts cycles with c_stall=1.
  - stat_dbg_grants counts d_gnt cycles.
  - Both counters saturate at 2^CNT_W-1 and clear on reset.
- DMEM_ARB_STATS_EN undefined: both outputs are tied to 0 and no counter flops exist.

## Test plan
- Reset: rst=0 with c_req=d_req=1 → m_en=0, c_stall=0, d_gnt=0. After release with both requesting, the core is granted in cycle 0.
- Core read only: c_req=1, c_we=0, c_addr=0x10 → m_en=1 and m_addr=0x10 that cycle. Next cycle c_rvalid=1 and c_rdata equals m_rdata; d_rvalid=0.
- Contention, MAX_WAIT=4, both requesting continuously → core granted in cycles 0-3, debug in cycle 4 (c_stall=1 only then), core again in cycle 5. The debug grant repeats every 5th cycle.
- Lock burst: core idle; debug writes 0x100/0x104/0x108 with d_lock=1,1,0; c_req rises in the 2nd cycle → d_gnt for 3 consecutive cycles. c_stall=1 for 2 cycles, and the core is granted in the cycle after the third write.
- Reset mid-LOCK: rst=0 for one cycle during a burst with c_req=1 → the core is granted in the first cycle after release, and no stale d_rvalid appears.
- Stats (DMEM_ARB_STATS_EN defined): after 10 cycles of the contention scenario → stat_stalls=2, stat_dbg_grants=2. With the macro undefined, both read 0.
